core_sys_pio_pulse_out: RTL and testbench
=========================================

Name: core_sys_pio_pulse_out

Overview:
Parametrised Avalon-MM slave output PIO for the HPS-to-fabric control path. Successor to the fixed 32-bit output port.
- Adds atomic set and clear writes.
- Adds self-timed output pulses: a programmable-length counter drives bits high, then auto-clears them.
- `out_port` drives fabric control lines such as LED strobes, peripheral resets and trigger lines.

Parameters:
- DATA_WIDTH, 32, number of output bits (1..32); bus bits above DATA_WIDTH are ignored on write and read as 0.
- RESET_VALUE, 0, reset value of the DATA register (DATA_WIDTH bits).
- CNT_WIDTH, 16, width of the PULSE_LEN register and the pulse down-counter (1..32).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is `chipselect && !write_n`.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states.
- out_port  out  DATA_WIDTH  output lines = data_reg OR pulse_mask.

Behaviour:
- Reset (async, reset_n=0):
  - data_reg=RESET_VALUE, pulse_mask=0, pulse_len=1, pulse_cnt=0, busy=0.
  - Hence out_port=RESET_VALUE; readdata follows address combinationally.
- Register map (word address):
  - 0 DATA, R/W: write loads data_reg; read returns data_reg only, pulse bits excluded.
  - 1 reserved: reads 0, writes ignored.
  - 2 PULSE_LEN, R/W: pulse length in clk cycles, CNT_WIDTH bits; a write of 0 is stored as 1.
  - 3 STATUS, R: bit0=busy; other bits 0 (see optional feature).
  - 4 OUTSET, W: data_reg |= writedata; reads 0.
  - 5 OUTCLEAR, W: data_reg &= ~writedata; reads 0.
  - 6 PULSE, W: starts or extends a pulse on the bits written as 1; reads 0.
  - 7 PULSE_MASK, R: current pulse_mask; writes ignored.
- Write latency: register updates on the clk edge where the write is sampled; out_port reflects it from the next cycle.
- Pulse state machine, states IDLE (busy=0) and ACTIVE (busy=1):
  - IDLE, PULSE write with nonzero mask m → ACTIVE. Sets pulse_mask=m and pulse_cnt=pulse_len.
  - IDLE, PULSE write with m=0 → no change.
  - ACTIVE, each cycle without a PULSE write:
    - if pulse_cnt==1: pulse_mask=0, pulse_cnt=0, → IDLE;
    - else pulse_cnt-=1.
  - ACTIVE, PULSE write with m≠0: pulse_mask|=m, pulse_cnt reloaded from pulse_len (retrigger), stay ACTIVE.
  - ACTIVE, PULSE write with m=0: ignored; countdown continues.
  - Expiry cycle coincides with a PULSE write (m≠0): write wins. pulse_mask=m (old bits dropped), counter reloaded, stay ACTIVE.
- Pulse bits are high on out_port for exactly pulse_len cycles, starting the cycle after the write.
- Pulse length is latched at start or retrigger; a PULSE_LEN write during ACTIVE affects only the next load.
- pulse_mask is independent of data_reg: a bit set in both stays high after pulse expiry; OUTCLEAR does not cancel a pulse.
- pulse_cnt never wraps; a decrement from 0 cannot occur.
- Reads have no side effects.
- Reset asserted mid-pulse: immediate return to reset values, glitch-free relative to the async clear.

Optional Feature:
Macro PIO_PULSE_IRQ_EN.
- When defined:
  - Extra output port `irq` (1 bit); sticky `done` flag at STATUS bit1 and interrupt enable `irq_en` at STATUS bit2.
  - `done` is set in the cycle ACTIVE→IDLE.
  - Writing STATUS: a 1 on bit1 clears `done`; bit2 writes `irq_en`.
  - Set and clear in the same cycle: set wins.
  - irq = done & irq_en, registered; reset to 0.
- When undefined: no `irq` port, STATUS bits 1 and 2 read 0, STATUS writes ignored.

Test Plan:
- Reset with RESET_VALUE=0x5: out_port=0x5, read addr 0 = 0x5, addr 3 = 0. Then write DATA=0xA5A5A5A5 → out_port=0xA5A5A5A5 next cycle.
- Set/clear on DATA=0x00F0: OUTSET 0x000F → 0x00FF; then OUTCLEAR 0x00F0 → 0x000F. Reads of addr 4 and 5 return 0.
- PULSE_LEN=5, PULSE 0x3:
  - bits[1:0] high for exactly 5 cycles, busy=1 throughout;
  - then 0, busy=0, PULSE_MASK reads 0.
- Retrigger: PULSE_LEN=4, PULSE 0x1, then PULSE 0x2 two cycles later → mask 0x3 held 4 more cycles after the second write.
- Collision and edge cases:
  - PULSE 0x4 written in the expiry cycle of a 0x1 pulse → mask becomes 0x4 with a fresh count;
  - PULSE_LEN write of 0 reads back 1 → 1-cycle pulse;
  - reset_n low mid-pulse → out_port=RESET_VALUE immediately.
- PIO_PULSE_IRQ_EN with irq_en=1, PULSE_LEN=3:
  - irq rises the cycle after expiry;
  - STATUS write 0x2 clears it;
  - clear coinciding with a new expiry leaves irq=1.

Source files
------------

// File: rtl/core_sys_pio_pulse_out_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : core_sys_pio_pulse_out_if
// Purpose  : Avalon-MM slave bus bundle for the pulse-capable output PIO.
//            Groups the word-addressed register bus so the PIO and its
//            master connect through a single port.
// Signals  : address    [2:0]  word address (master -> slave)
//            chipselect        slave select (master -> slave)
//            write_n           active-low write strobe (master -> slave)
//            writedata  [31:0] write data (master -> slave)
//            readdata   [31:0] combinational read data (slave -> master)
// Modports : master, slave
// Revision : 1.0 - initial release
// ============================================================================
interface core_sys_pio_pulse_out_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface : core_sys_pio_pulse_out_if
`default_nettype wire

// File: rtl/core_sys_pio_pulse_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : core_sys_pio_pulse_out
// Purpose  : Parametrised Avalon-MM slave output PIO for the HPS-to-fabric
//            control path. Provides a plain DATA register, atomic set/clear
//            writes and self-timed output pulses that auto-clear after a
//            programmable number of clock cycles.
//
// Parameters:
//   DATA_WIDTH  - number of output bits (1..32)
//   RESET_VALUE - reset value of the DATA register (low DATA_WIDTH bits used)
//   CNT_WIDTH   - width of PULSE_LEN and the pulse down-counter (1..32)
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   reset_n  in   asynchronous active-low reset
//   avs      slv  register bus (address/chipselect/write_n/writedata/readdata)
//   out_port out  DATA_WIDTH output lines = data register OR pulse mask
//   irq      out  registered interrupt (only with PIO_PULSE_IRQ_EN)
//
// Register map (word address):
//   0 DATA        R/W  data register
//   1 reserved    reads 0, writes ignored
//   2 PULSE_LEN   R/W  pulse length in cycles, a write of 0 stores 1
//   3 STATUS      R    bit0 busy; with PIO_PULSE_IRQ_EN: bit1 done (W1C),
//                      bit2 irq_en (R/W)
//   4 OUTSET      W    data |= writedata
//   5 OUTCLEAR    W    data &= ~writedata
//   6 PULSE       W    start / extend a pulse on the bits written as 1
//   7 PULSE_MASK  R    current pulse mask
//
// Optional feature macro: PIO_PULSE_IRQ_EN (pulse-done interrupt)
//
// Revision : 1.0 - initial release
// ============================================================================
module core_sys_pio_pulse_out #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    core_sys_pio_pulse_out_if.slave     avs,
    output logic [DATA_WIDTH-1:0]       out_port
`ifdef PIO_PULSE_IRQ_EN
    ,
    output logic                        irq
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ADDR_DATA     = 3'd0;
    localparam logic [2:0] c_ADDR_PLEN     = 3'd2;
    localparam logic [2:0] c_ADDR_STATUS   = 3'd3;
    localparam logic [2:0] c_ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] c_ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] c_ADDR_PULSE    = 3'd6;
    localparam logic [2:0] c_ADDR_PMASK    = 3'd7;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State registers and next-state values
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_q,       data_d;
    logic [DATA_WIDTH-1:0] pulse_mask_q, pulse_mask_d;
    logic [CNT_WIDTH-1:0]  pulse_len_q,  pulse_len_d;
    logic [CNT_WIDTH-1:0]  pulse_cnt_q,  pulse_cnt_d;
    logic [0:0]            state_q,      state_d;

    // ------------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------------
    logic                  w_wr;
    logic                  w_wr_data;
    logic                  w_wr_plen;
    logic                  w_wr_outset;
    logic                  w_wr_outclear;
    logic                  w_wr_pulse;
    logic [DATA_WIDTH-1:0] w_wdata_dw;
    logic [CNT_WIDTH-1:0]  w_wdata_cnt;
    logic                  w_pulse_req;
    logic                  w_cnt_last;
    logic                  w_busy;
    logic                  w_expire;

    assign w_wr          = avs.chipselect & ~avs.write_n;
    assign w_wr_data     = w_wr && (avs.address == c_ADDR_DATA);
    assign w_wr_plen     = w_wr && (avs.address == c_ADDR_PLEN);
    assign w_wr_outset   = w_wr && (avs.address == c_ADDR_OUTSET);
    assign w_wr_outclear = w_wr && (avs.address == c_ADDR_OUTCLEAR);
    assign w_wr_pulse    = w_wr && (avs.address == c_ADDR_PULSE);

    // Bus bits above the implemented widths are simply dropped here.
    assign w_wdata_dw    = avs.writedata[DATA_WIDTH-1:0];
    assign w_wdata_cnt   = avs.writedata[CNT_WIDTH-1:0];

    // A PULSE write of all-zero bits is a no-op in every state.
    assign w_pulse_req   = w_wr_pulse && (w_wdata_dw != '0);
    assign w_cnt_last    = (pulse_cnt_q == c_CNT_ONE);
    assign w_busy        = (state_q == c_ST_ACTIVE);

    // Natural end of a pulse: last count with no competing PULSE write.
    assign w_expire      = w_busy && w_cnt_last && !w_pulse_req;

    // ------------------------------------------------------------------------
    // DATA and PULSE_LEN registers
    // ------------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        if (w_wr_data) begin
            data_d = w_wdata_dw;
        end else if (w_wr_outset) begin
            data_d = data_q | w_wdata_dw;
        end else if (w_wr_outclear) begin
            data_d = data_q & ~w_wdata_dw;
        end
    end

    always_comb begin
        pulse_len_d = pulse_len_q;
        if (w_wr_plen) begin
            // Zero length is promoted to one so a started pulse is always
            // visible and the counter can never be loaded with 0.
            pulse_len_d = (w_wdata_cnt == '0) ? c_CNT_ONE : w_wdata_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Pulse state machine
    // The counter holds the number of cycles the mask has left on out_port,
    // including the current one; the mask drops on the edge where it is 1.
    // Retrigger loads from pulse_len_q (pre-write value), so a PULSE_LEN write
    // in the same cycle only affects later loads.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pulse_mask_d = pulse_mask_q;
        pulse_cnt_d  = pulse_cnt_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_pulse_req) begin
                    state_d      = c_ST_ACTIVE;
                    pulse_mask_d = w_wdata_dw;
                    pulse_cnt_d  = pulse_len_q;
                end
            end
            c_ST_ACTIVE: begin
                if (w_pulse_req) begin
                    // On the expiry cycle the old bits are due to drop, so
                    // the new write replaces the mask instead of merging.
                    pulse_mask_d = w_cnt_last ? w_wdata_dw
                                              : (pulse_mask_q | w_wdata_dw);
                    pulse_cnt_d  = pulse_len_q;
                end else if (w_cnt_last) begin
                    state_d      = c_ST_IDLE;
                    pulse_mask_d = '0;
                    pulse_cnt_d  = '0;
                end else begin
                    pulse_cnt_d  = pulse_cnt_q - c_CNT_ONE;
                end
            end
            default: begin
                state_d      = c_ST_IDLE;
                pulse_mask_d = '0;
                pulse_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= RESET_VALUE[DATA_WIDTH-1:0];
            pulse_mask_q <= '0;
            pulse_len_q  <= c_CNT_ONE;
            pulse_cnt_q  <= '0;
            state_q      <= c_ST_IDLE;
        end else begin
            data_q       <= data_d;
            pulse_mask_q <= pulse_mask_d;
            pulse_len_q  <= pulse_len_d;
            pulse_cnt_q  <= pulse_cnt_d;
            state_q      <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Pulse-done interrupt (optional)
    // ------------------------------------------------------------------------
    logic [31:0] w_status;

`ifdef PIO_PULSE_IRQ_EN
    logic w_wr_status;
    logic done_q,   done_d;
    logic irq_en_q, irq_en_d;
    logic irq_q,    irq_d;

    assign w_wr_status = w_wr && (avs.address == c_ADDR_STATUS);

    always_comb begin
        done_d   = done_q;
        irq_en_d = irq_en_q;
        // Set has priority over a same-cycle write-1-to-clear.
        if (w_expire) begin
            done_d = 1'b1;
        end else if (w_wr_status && avs.writedata[1]) begin
            done_d = 1'b0;
        end
        if (w_wr_status) begin
            irq_en_d = avs.writedata[2];
        end
        // Computed from next-state values so irq tracks done on the same
        // edge while still coming straight from a flop.
        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq      = irq_q;
    assign w_status = {29'd0, irq_en_q, done_q, w_busy};
`else
    // Expiry only matters to the interrupt logic.
    logic w_expire_unused;
    assign w_expire_unused = w_expire;
    assign w_status        = {31'd0, w_busy};
`endif

    // ------------------------------------------------------------------------
    // Read mux (combinational, zero wait states, no side effects)
    // ------------------------------------------------------------------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (avs.address)
            c_ADDR_DATA:   w_rdata[DATA_WIDTH-1:0] = data_q;
            c_ADDR_PLEN:   w_rdata[CNT_WIDTH-1:0]  = pulse_len_q;
            c_ADDR_STATUS: w_rdata                 = w_status;
            c_ADDR_PMASK:  w_rdata[DATA_WIDTH-1:0] = pulse_mask_q;
            default:       w_rdata                 = '0;
        endcase
    end

    assign avs.readdata = w_rdata;

    // ------------------------------------------------------------------------
    // Output lines: DATA and pulse bits are independent contributors.
    // ------------------------------------------------------------------------
    assign out_port = data_q | pulse_mask_q;

endmodule : core_sys_pio_pulse_out
`default_nettype wire

// File: tb/tb_core_sys_pio_pulse_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_core_sys_pio_pulse_out
// Purpose  : Self-checking bench for core_sys_pio_pulse_out. Expected values
//            are queued when stimulus is driven and drained against the DUT
//            outputs on the falling clock edge (or immediately for async and
//            combinational observations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_sys_pio_pulse_out;

    localparam logic [31:0] c_RST_VAL = 32'h0000_0005;
    localparam int          K_OUT     = 0;
    localparam int          K_RD      = 1;
    localparam int          K_IRQ     = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] out_port;
`ifdef PIO_PULSE_IRQ_EN
    logic        irq;
`endif

    core_sys_pio_pulse_out_if bus_if ();

    core_sys_pio_pulse_out #(
        .DATA_WIDTH  (32),
        .RESET_VALUE (c_RST_VAL),
        .CNT_WIDTH   (16)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus_if),
        .out_port (out_port)
`ifdef PIO_PULSE_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    string       q_tag[$];
    int          q_kind[$];
    logic [31:0] q_exp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [31:0] exp);
        q_tag.push_back(tag);
        q_kind.push_back(kind);
        q_exp.push_back(exp);
    endtask

    task automatic drain();
        string       tag;
        int          kind;
        logic [31:0] exp;
        logic [31:0] obs;
        while (q_tag.size() > 0) begin
            tag  = q_tag.pop_front();
            kind = q_kind.pop_front();
            exp  = q_exp.pop_front();
            obs  = 'x;
            case (kind)
                K_OUT:   obs = out_port;
                K_RD:    obs = bus_if.readdata;
`ifdef PIO_PULSE_IRQ_EN
                K_IRQ:   obs = {31'd0, irq};
`endif
                default: obs = 'x;
            endcase
            chk(tag, obs, exp);
        end
    endtask

    task automatic observe();
        @(negedge clk);
        drain();
    endtask

    // Leaves the bus reading STATUS so busy can be sampled every cycle.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        @(posedge clk);
        #1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 3'd3;
        bus_if.writedata  = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        #1;
        push(tag, K_RD, exp);
        drain();
        bus_if.address    = 3'd3;
    endtask

    task automatic pulse_obs(input string tag, input int n, input logic [31:0] outv,
                             input logic [31:0] status);
        for (int i = 0; i < n; i++) begin
            push({tag, "_out"}, K_OUT, outv);
            push({tag, "_busy"}, K_RD, status);
            observe();
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset_n           = 1'b0;
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
        repeat (3) @(negedge clk);
        push("rst_out_in_reset", K_OUT, c_RST_VAL);
        drain();
        reset_n = 1'b1;
        push("rst_out", K_OUT, c_RST_VAL);
`ifdef PIO_PULSE_IRQ_EN
        push("rst_irq", K_IRQ, 32'h0);
`endif
        observe();
        rd_chk("rst_rd_data", 3'd0, c_RST_VAL);
        rd_chk("rst_rd_status", 3'd3, 32'h0);
        rd_chk("rst_rd_plen", 3'd2, 32'h1);

        // DATA write
        bus_write(3'd0, 32'hA5A5_A5A5);
        push("data_out", K_OUT, 32'hA5A5_A5A5);
        observe();
        rd_chk("data_rd", 3'd0, 32'hA5A5_A5A5);

        // Atomic set / clear and reserved/write-only reads
        bus_write(3'd0, 32'h0000_00F0);
        bus_write(3'd4, 32'h0000_000F);
        push("outset_out", K_OUT, 32'h0000_00FF);
        observe();
        bus_write(3'd5, 32'h0000_00F0);
        push("outclr_out", K_OUT, 32'h0000_000F);
        observe();
        rd_chk("rd_outset", 3'd4, 32'h0);
        rd_chk("rd_outclr", 3'd5, 32'h0);
        bus_write(3'd1, 32'hFFFF_FFFF);
        rd_chk("rd_reserved", 3'd1, 32'h0);
        rd_chk("data_after_rsvd", 3'd0, 32'h0000_000F);

        // Basic pulse, length 5
        bus_write(3'd0, 32'h0000_0100);
        bus_write(3'd2, 32'd5);
        rd_chk("plen_rd", 3'd2, 32'd5);
        bus_write(3'd6, 32'h0000_0003);
        rd_chk("pmask_active", 3'd7, 32'h3);
        rd_chk("data_excl_pulse", 3'd0, 32'h0000_0100);
        pulse_obs("pulse5", 5, 32'h0000_0103, 32'h1);
        pulse_obs("pulse5_end", 1, 32'h0000_0100, 32'h0);
        rd_chk("pmask_idle", 3'd7, 32'h0);

        // Retrigger two cycles into a 4-cycle pulse
        bus_write(3'd2, 32'd4);
        bus_write(3'd6, 32'h0000_0001);
        pulse_obs("retrig_a", 2, 32'h0000_0101, 32'h1);
        bus_write(3'd6, 32'h0000_0002);
        pulse_obs("retrig_b", 4, 32'h0000_0103, 32'h1);
        pulse_obs("retrig_end", 1, 32'h0000_0100, 32'h0);

        // PULSE write landing on the expiry cycle
        bus_write(3'd2, 32'd3);
        bus_write(3'd6, 32'h0000_0001);
        pulse_obs("coll_a", 3, 32'h0000_0101, 32'h1);
        bus_write(3'd6, 32'h0000_0004);
        pulse_obs("coll_b", 3, 32'h0000_0104, 32'h1);
        pulse_obs("coll_end", 1, 32'h0000_0100, 32'h0);

        // Zero PULSE write while idle does nothing
        bus_write(3'd6, 32'h0000_0000);
        pulse_obs("zero_pulse", 1, 32'h0000_0100, 32'h0);

        // PULSE_LEN of zero stored as one
        bus_write(3'd2, 32'd0);
        rd_chk("plen_zero_rd", 3'd2, 32'd1);
        bus_write(3'd6, 32'h0000_0008);
        pulse_obs("len1", 1, 32'h0000_0108, 32'h1);
        pulse_obs("len1_end", 1, 32'h0000_0100, 32'h0);

        // Async reset in the middle of a pulse
        bus_write(3'd2, 32'd5);
        bus_write(3'd6, 32'h0000_0010);
        pulse_obs("prerst", 2, 32'h0000_0110, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        push("midrst_out", K_OUT, c_RST_VAL);
        drain();
        rd_chk("midrst_data", 3'd0, c_RST_VAL);
        rd_chk("midrst_pmask", 3'd7, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        pulse_obs("postrst", 1, c_RST_VAL, 32'h0);

`ifdef PIO_PULSE_IRQ_EN
        bus_write(3'd3, 32'h0000_0004);
        rd_chk("irq_en_rd", 3'd3, 32'h4);
        bus_write(3'd2, 32'd3);
        bus_write(3'd6, 32'h0000_0002);
        for (int i = 0; i < 3; i++) begin
            push("irq_pulse_out", K_OUT, 32'h7);
            push("irq_pulse_irq", K_IRQ, 32'h0);
            push("irq_pulse_st", K_RD, 32'h5);
            observe();
        end
        push("irq_exp_out", K_OUT, 32'h5);
        push("irq_exp_irq", K_IRQ, 32'h1);
        push("irq_exp_st", K_RD, 32'h6);
        observe();
        bus_write(3'd3, 32'h0000_0006);
        push("irq_clr_irq", K_IRQ, 32'h0);
        push("irq_clr_st", K_RD, 32'h4);
        observe();
        bus_write(3'd6, 32'h0000_0002);
        for (int i = 0; i < 3; i++) begin
            push("irq_p2_out", K_OUT, 32'h7);
            push("irq_p2_irq", K_IRQ, 32'h0);
            observe();
        end
        bus_write(3'd3, 32'h0000_0006);
        push("irq_coll_out", K_OUT, 32'h5);
        push("irq_coll_irq", K_IRQ, 32'h1);
        push("irq_coll_st", K_RD, 32'h6);
        observe();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_core_sys_pio_pulse_out
`default_nettype wire
